// File: rtl/cdc_pkg.sv
// Shared constants for the sclk->pclk transmit arbiter.
// Optional statistics outputs are enabled with the CDC_TX_STATS_EN macro.
package cdc_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ_HI = 2'd1;
  localparam logic [1:0] ST_REQ_LO = 2'd2;

  // Default geometry
  localparam int unsigned DEF_DATA_W      = 6;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Statistics: transfer counter saturation and handshake dwell timeout
  localparam int unsigned STATS_CNT_W   = 16;
  localparam logic [15:0] STATS_SAT     = 16'hFFFF;
  localparam int unsigned DWELL_W       = 8;
  localparam int unsigned TIMEOUT_LIMIT = 255;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with async active-low reset.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC channel (sclk -> pclk).
// Define CDC_TX_STATS_EN to add the xfer_count / ack_timeout outputs.
module cdc_tx_arbiter
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                       sclk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       xfer_req,
  output logic [DATA_W-1:0]          xfer_data,
  input  logic                       xfer_ack_async,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef CDC_TX_STATS_EN
  ,
  output logic [15:0]                xfer_count,
  output logic                       ack_timeout
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [1:0]        state_q, state_nxt;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_nxt;
  logic [ID_W-1:0]   grant_id_nxt;
  logic              xfer_req_nxt;
  logic [DATA_W-1:0] xfer_data_nxt;
  logic              ack_s;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic              win_vld_c;
  logic [ID_W-1:0]   win_id_c;
  logic [DATA_W-1:0] win_data_c;

  // Bring the receiver ack into sclk
  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (sclk),
    .rst_n (rst_n),
    .d     (xfer_ack_async),
    .q     (ack_s)
  );

  // Unpack requester payloads
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: first valid at or above the pointer, wrapping
  always_comb begin
    int unsigned cand;
    win_vld_c  = 1'b0;
    win_id_c   = '0;
    win_data_c = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_vld_c && req_valid[ID_W'(cand)]) begin
        win_vld_c  = 1'b1;
        win_id_c   = ID_W'(cand);
        win_data_c = data_arr[ID_W'(cand)];
      end
    end
  end

  // State and handshake output registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_id  <= '0;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
    end else begin
      state_q   <= state_nxt;
      rr_ptr_q  <= rr_ptr_nxt;
      grant_id  <= grant_id_nxt;
      xfer_req  <= xfer_req_nxt;
      xfer_data <= xfer_data_nxt;
    end
  end

  // Next-state logic; a grant only happens in IDLE once the ack has released
  always_comb begin
    state_nxt     = state_q;
    rr_ptr_nxt    = rr_ptr_q;
    grant_id_nxt  = grant_id;
    xfer_req_nxt  = xfer_req;
    xfer_data_nxt = xfer_data;
    req_ready     = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_c && !ack_s) begin
          req_ready     = NUM_REQ'(1) << win_id_c;
          xfer_data_nxt = win_data_c;
          grant_id_nxt  = win_id_c;
          rr_ptr_nxt    = (win_id_c == ID_W'(NUM_REQ - 1)) ? '0 : win_id_c + ID_W'(1);
          xfer_req_nxt  = 1'b1;
          state_nxt     = ST_REQ_HI;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          xfer_req_nxt = 1'b0;
          state_nxt    = ST_REQ_LO;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        xfer_req_nxt = 1'b0;
        state_nxt    = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

`ifdef CDC_TX_STATS_EN
  logic [DWELL_W-1:0] dwell_q;

  // Completed-transfer counter and sticky handshake-stall flag
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count  <= '0;
      ack_timeout <= 1'b0;
      dwell_q     <= '0;
    end else begin
      if (state_q == ST_REQ_LO && state_nxt == ST_IDLE && xfer_count != STATS_SAT) begin
        xfer_count <= xfer_count + 16'd1;
      end
      if (state_nxt != state_q || state_q == ST_IDLE) begin
        dwell_q <= '0;
      end else if (dwell_q != DWELL_W'(TIMEOUT_LIMIT)) begin
        dwell_q <= dwell_q + DWELL_W'(1);
      end else begin
        ack_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter (NUM_REQ=4, DATA_W=6, SYNC_STAGES=2).
// Honours CDC_TX_STATS_EN when the design is built with it.
module tb_cdc_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 6;

  logic            sclk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            xfer_req;
  logic [DW-1:0]   xfer_data;
  logic            xfer_ack_async;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef CDC_TX_STATS_EN
  logic [15:0]     xfer_count;
  logic            ack_timeout;
`endif

  logic [DW-1:0] dat [N];
  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  cdc_tx_arbiter dut (
    .sclk           (sclk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .grant_id       (grant_id),
    .busy           (busy)
`ifdef CDC_TX_STATS_EN
    ,
    .xfer_count     (xfer_count),
    .ack_timeout    (ack_timeout)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;   // reference round-robin pointer
  int done_n = 0;   // reference completed-transfer count

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: first valid requester scanning upward from the pointer with wrap
  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One complete 4-phase transfer, starting at a negedge in IDLE
  task automatic run_xfer(input int up_dly, input int dn_dly, input bit drop_after, output int gw);
    int            exp_w;
    logic [DW-1:0] exp_d;
    bit            found;
    found = 1'b0;
    exp_w = model_winner(req_valid);
    gw    = -1;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (req_ready != '0) found = 1'b1;
      else @(negedge sclk);
    end
    check("accept_seen", 32'(found), 32'd1);
    if (!found || exp_w < 0) return;
    exp_d = dat[exp_w];
    check("req_ready_onehot", 32'(req_ready), 32'(1) << exp_w);
    gw    = exp_w;
    m_ptr = (exp_w + 1) % N;
    @(negedge sclk);
    if (drop_after) req_valid[exp_w] = 1'b0;
    check("xfer_req_rise", 32'(xfer_req), 32'd1);
    check("grant_id", 32'(grant_id), 32'(exp_w));
    check("xfer_data", 32'(xfer_data), 32'(exp_d));
    check("busy_hi", 32'(busy), 32'd1);
    check("no_ready_busy", 32'(req_ready), 32'd0);
    repeat (up_dly) begin
      @(negedge sclk);
      check("hold_req", 32'(xfer_req), 32'd1);
      check("hold_data", 32'(xfer_data), 32'(exp_d));
      check("hold_no_ready", 32'(req_ready), 32'd0);
    end
    xfer_ack_async = 1'b1;
    repeat (2) @(negedge sclk);
    check("ack_lat_still_hi", 32'(xfer_req), 32'd1);
    @(negedge sclk);
    check("ack_lat_fall", 32'(xfer_req), 32'd0);
    check("lo_data", 32'(xfer_data), 32'(exp_d));
    repeat (dn_dly) begin
      @(negedge sclk);
      check("lo_req", 32'(xfer_req), 32'd0);
      check("lo_hold_data", 32'(xfer_data), 32'(exp_d));
      check("lo_busy", 32'(busy), 32'd1);
      check("lo_no_ready", 32'(req_ready), 32'd0);
    end
    xfer_ack_async = 1'b0;
    repeat (2) @(negedge sclk);
    check("rel_busy_hi", 32'(busy), 32'd1);
    @(negedge sclk);
    check("idle_busy_lo", 32'(busy), 32'd0);
    check("idle_grant_kept", 32'(grant_id), 32'(exp_w));
    done_n++;
  endtask

  initial begin
    int gw;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n          = 1'b1;
    req_valid      = '0;
    xfer_ack_async = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = '0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_xfer_req", 32'(xfer_req), 32'd0);
    check("rst_xfer_data", 32'(xfer_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef CDC_TX_STATS_EN
    check("rst_xfer_count", 32'(xfer_count), 32'd0);
    check("rst_ack_timeout", 32'(ack_timeout), 32'd0);
`endif
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    check("idle_no_req", 32'(xfer_req), 32'd0);

    // Round-robin with all four continuously valid
    for (int i = 0; i < N; i++) dat[i] = DW'(6'h10 + i);
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      run_xfer(3, 3, 1'b0, gw);
      check("rr_order", 32'(gw), 32'(exp_order[t]));
    end
`ifdef CDC_TX_STATS_EN
    check("stats_count5", 32'(xfer_count), 32'd5);
`endif

    // Single request from requester 1
    req_valid = 4'b0010;
    dat[1]    = 6'h2A;
    run_xfer(3, 3, 1'b1, gw);
    check("single_grant", 32'(gw), 32'd1);
    check("single_valid_dropped", 32'(req_valid), 32'd0);

    // Fairness after skip: pointer at 2, requesters 0 and 3 valid
    req_valid = 4'b1001;
    dat[0]    = 6'h05;
    dat[3]    = 6'h33;
    run_xfer(1, 2, 1'b0, gw);
    check("skip_grant3", 32'(gw), 32'd3);
    run_xfer(2, 1, 1'b0, gw);
    check("skip_grant0", 32'(gw), 32'd0);

    // Slow acknowledge
    req_valid = 4'b0100;
    dat[2]    = 6'h15;
    run_xfer(40, 5, 1'b1, gw);
    check("slow_grant", 32'(gw), 32'd2);
`ifdef CDC_TX_STATS_EN
    check("no_timeout_40", 32'(ack_timeout), 32'd0);
    req_valid = 4'b1000;
    dat[3]    = 6'h2C;
    run_xfer(300, 2, 1'b1, gw);
    check("timeout_300", 32'(ack_timeout), 32'd1);
    check("stats_count", 32'(xfer_count), 32'(done_n));
`endif

    // Reset in the middle of REQ_HI
    req_valid = 4'b0100;
    dat[2]    = 6'h1B;
    @(negedge sclk);
    check("pre_rst_req", 32'(xfer_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_xfer_req", 32'(xfer_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
`ifdef CDC_TX_STATS_EN
    check("midrst_timeout", 32'(ack_timeout), 32'd0);
    check("midrst_count", 32'(xfer_count), 32'd0);
`endif
    req_valid = '0;
    repeat (2) @(negedge sclk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    done_n = 0;
    @(negedge sclk);
    dat[0]    = 6'h3F;
    req_valid = 4'b0001;
    run_xfer(2, 2, 1'b1, gw);
    check("post_rst_grant", 32'(gw), 32'd0);

    // Randomized masks, payloads and ack timing against the reference
    for (int t = 0; t < 25; t++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
      req_valid = m;
      run_xfer(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'($urandom), gw);
    end
`ifdef CDC_TX_STATS_EN
    check("final_count", 32'(xfer_count), 32'(done_n));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
